// File: rtl/pool1d_window_buffer.sv
// Sliding 1-D pooling window: pads each row with zeros, shifts elements into a
// K-deep window and emits it one cycle after the slot that completes it.
module pool1d_window_buffer #(
   parameter int DATA_IN_0_PRECISION_0       = 8,
   parameter int DATA_IN_0_TENSOR_SIZE_DIM_0 = 8,
   parameter int DATA_IN_0_TENSOR_SIZE_DIM_1 = 1,
   parameter int KERNEL_SIZE                 = 2,
   parameter int STRIDE                      = 2,
   parameter int PADDING                     = 0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0,
   input  logic                             data_in_0_valid,
   output logic                             data_in_0_ready,
   output logic [DATA_IN_0_PRECISION_0-1:0] data_out_0 [KERNEL_SIZE-1:0],
   output logic                             data_out_0_valid,
   input  logic                             data_out_0_ready
);

   localparam int W  = DATA_IN_0_PRECISION_0;
   localparam int N  = DATA_IN_0_TENSOR_SIZE_DIM_0;
   localparam int R  = DATA_IN_0_TENSOR_SIZE_DIM_1;
   localparam int K  = KERNEL_SIZE;
   localparam int L  = N + 2 * PADDING;
   localparam int PW = $clog2(L + 1);
   localparam int RW = (R > 1) ? $clog2(R) : 1;
   localparam int MW = 1 << PW;

   if (KERNEL_SIZE < 1 || STRIDE < 1 || PADDING >= KERNEL_SIZE || L < KERNEL_SIZE) begin : g_param_check
      $error("pool1d_window_buffer: invalid KERNEL_SIZE/STRIDE/PADDING for this row length");
   end

   // Per-slot properties are fixed by the parameters, so they become constant lookup masks.
   function automatic logic [MW-1:0] pad_slots();
      logic [MW-1:0] m;
      m = '0;
      for (int i = 0; i < L; i++) m[i] = (i < PADDING) || (i >= PADDING + N);
      return m;
   endfunction

   function automatic logic [MW-1:0] done_slots();
      logic [MW-1:0] m;
      m = '0;
      for (int i = 0; i < L; i++)
         if (i >= K - 1 && ((i - (K - 1)) % ((STRIDE > 0) ? STRIDE : 1)) == 0) m[i] = 1'b1;
      return m;
   endfunction

   localparam logic [MW-1:0] PAD_SLOT  = pad_slots();
   localparam logic [MW-1:0] DONE_SLOT = done_slots();
   localparam logic [PW-1:0] LAST_POS  = PW'(L - 1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(R - 1);

   logic [PW-1:0] pos;
   logic [RW-1:0] row;
   logic [W-1:0]  win     [K-1:0];
   logic [W-1:0]  win_nxt [K-1:0];
   logic [W-1:0]  ins;
   logic          is_pad;
   logic          is_done;
   logic          allow;
   logic          advance;

   assign is_pad  = PAD_SLOT[pos];
   assign is_done = DONE_SLOT[pos];
   // A completing slot may only proceed if the output register is free or draining now.
   assign allow   = !(is_done && data_out_0_valid && !data_out_0_ready);
   assign advance = allow && (is_pad || data_in_0_valid);
   assign data_in_0_ready = !rst && !is_pad && allow;
   assign ins     = is_pad ? '0 : data_in_0;

   always_comb begin
      for (int i = 0; i < K - 1; i++) win_nxt[i] = win[i + 1];
      win_nxt[K-1] = ins;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos              <= '0;
         row              <= '0;
         data_out_0_valid <= 1'b0;
         for (int i = 0; i < K; i++) begin
            win[i]        <= '0;
            data_out_0[i] <= '0;
         end
      end else begin
         if (advance) begin
            if (pos == LAST_POS) begin
               pos <= '0;
               row <= (row == LAST_ROW) ? '0 : row + RW'(1);
               for (int i = 0; i < K; i++) win[i] <= '0;
            end else begin
               pos <= pos + PW'(1);
               for (int i = 0; i < K; i++) win[i] <= win_nxt[i];
            end
         end
         if (advance && is_done) begin
            data_out_0_valid <= 1'b1;
            for (int i = 0; i < K; i++) data_out_0[i] <= win_nxt[i];
         end else if (data_out_0_valid && data_out_0_ready) begin
            data_out_0_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pool1d_window_buffer.sv
// Bench for pool1d_window_buffer: four parameterisations driven by tasks and
// checked against a padded-sequence window model.
module tb_pool1d_window_buffer;

   typedef logic [31:0] wq_t[$];

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din [4];
   logic [3:0] vin  = '0;
   logic [3:0] rout = '1;
   wire  [3:0] rin;
   wire  [3:0] vout;
   logic [7:0] dout0 [1:0];
   logic [7:0] dout1 [2:0];
   logic [7:0] dout2 [1:0];
   logic [7:0] dout3 [2:0];
   logic [31:0] pk0, pk1, pk2, pk3;
   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [31:0] cap0[$], cap1[$], cap2[$], cap3[$];
   int cyc3[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign pk0 = {16'h0, dout0[1], dout0[0]};
   assign pk1 = {8'h0, dout1[2], dout1[1], dout1[0]};
   assign pk2 = {16'h0, dout2[1], dout2[0]};
   assign pk3 = {8'h0, dout3[2], dout3[1], dout3[0]};

   pool1d_window_buffer #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_TENSOR_SIZE_DIM_0(8), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
      .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0)) u_d0 (
      .clk(clk), .rst(rst), .data_in_0(din[0]), .data_in_0_valid(vin[0]), .data_in_0_ready(rin[0]),
      .data_out_0(dout0), .data_out_0_valid(vout[0]), .data_out_0_ready(rout[0]));

   pool1d_window_buffer #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_TENSOR_SIZE_DIM_0(5), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
      .KERNEL_SIZE(3), .STRIDE(2), .PADDING(1)) u_d1 (
      .clk(clk), .rst(rst), .data_in_0(din[1]), .data_in_0_valid(vin[1]), .data_in_0_ready(rin[1]),
      .data_out_0(dout1), .data_out_0_valid(vout[1]), .data_out_0_ready(rout[1]));

   pool1d_window_buffer #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_TENSOR_SIZE_DIM_0(7), .DATA_IN_0_TENSOR_SIZE_DIM_1(2),
      .KERNEL_SIZE(2), .STRIDE(2), .PADDING(0)) u_d2 (
      .clk(clk), .rst(rst), .data_in_0(din[2]), .data_in_0_valid(vin[2]), .data_in_0_ready(rin[2]),
      .data_out_0(dout2), .data_out_0_valid(vout[2]), .data_out_0_ready(rout[2]));

   pool1d_window_buffer #(.DATA_IN_0_PRECISION_0(8), .DATA_IN_0_TENSOR_SIZE_DIM_0(8), .DATA_IN_0_TENSOR_SIZE_DIM_1(1),
      .KERNEL_SIZE(3), .STRIDE(1), .PADDING(0)) u_d3 (
      .clk(clk), .rst(rst), .data_in_0(din[3]), .data_in_0_valid(vin[3]), .data_in_0_ready(rin[3]),
      .data_out_0(dout3), .data_out_0_valid(vout[3]), .data_out_0_ready(rout[3]));

   // Transfers are recorded half a cycle before the edge that completes them.
   always @(negedge clk) begin
      if (!rst) begin
         if (vout[0] && rout[0]) cap0.push_back(pk0);
         if (vout[1] && rout[1]) cap1.push_back(pk1);
         if (vout[2] && rout[2]) cap2.push_back(pk2);
         if (vout[3] && rout[3]) begin
            cap3.push_back(pk3);
            cyc3.push_back(cyc);
         end
      end
   end

   // Expected windows: build each padded row, then slice every window start 0, S, 2S...
   function automatic wq_t model(input int n, input int k, input int s, input int p, input int vals[$]);
      wq_t q;
      int seq[$];
      logic [31:0] w;
      int l;
      l = n + 2 * p;
      for (int r = 0; r < vals.size() / n; r++) begin
         seq.delete();
         repeat (p) seq.push_back(0);
         for (int j = 0; j < n; j++) seq.push_back(vals[r * n + j]);
         repeat (p) seq.push_back(0);
         for (int st = 0; st + k <= l; st += s) begin
            w = '0;
            for (int j = 0; j < k; j++) w = w | ((32'(seq[st + j]) & 32'hff) << (8 * j));
            q.push_back(w);
         end
      end
      return q;
   endfunction

   // Called just after a rising edge; returns just after a rising edge.
   task automatic drive(input int id, input int vals[$], input bit rnd);
      int  i;
      int  guard;
      bit  acc;
      i = 0;
      guard = 0;
      while (i < vals.size() && guard < 2000) begin
         din[id] = 8'(vals[i]);
         vin[id] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (rnd) rout[id] = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         acc = vin[id] && rin[id];
         @(posedge clk);
         #1;
         if (acc) i++;
         guard++;
      end
      vin[id] = 1'b0;
      if (guard >= 2000) begin
         total++; bad++;
         $display("FAIL drive%0d_timeout: accepted %0d of %0d elements", id, i, vals.size());
      end
   endtask

   task automatic drain(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      total++; if (vout !== 4'b0000) begin bad++; $display("FAIL reset_valid: got %b want 0000", vout); end
      total++; if (rin !== 4'b0000) begin bad++; $display("FAIL reset_in_ready: got %b want 0000", rin); end
      total++; if ({pk0, pk1, pk2, pk3} !== 128'h0) begin bad++; $display("FAIL reset_data: got %h want 0", {pk0, pk1, pk2, pk3}); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      total++; if (rin[0] !== 1'b1) begin bad++; $display("FAIL post_reset_ready: got %b want 1", rin[0]); end
   endtask

   task automatic test_basic();
      int  vals[$];
      wq_t exp;
      cap0.delete();
      rout[0] = 1'b1;
      for (int i = 1; i <= 8; i++) vals.push_back(i);
      exp = model(8, 2, 2, 0, vals);
      drive(0, vals, 0);
      drain(5);
      total++; if (cap0.size() != exp.size()) begin bad++; $display("FAIL basic_count: got %0d want %0d", cap0.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < cap0.size(); i++) begin
         total++; if (cap0[i] !== exp[i]) begin bad++; $display("FAIL basic_win%0d: got %h want %h", i, cap0[i], exp[i]); end
      end
      total++; if (vout[0] !== 1'b0) begin bad++; $display("FAIL basic_idle_valid: got %b want 0", vout[0]); end
   endtask

   task automatic test_padding();
      int  vals[$];
      wq_t exp;
      cap1.delete();
      rout[1] = 1'b1;
      for (int i = 1; i <= 5; i++) vals.push_back(i);
      exp = model(5, 3, 2, 1, vals);
      drive(1, vals, 0);
      @(negedge clk);
      total++; if (rin[1] !== 1'b0) begin bad++; $display("FAIL pad_tail_ready: got %b want 0", rin[1]); end
      @(negedge clk);
      total++; if (rin[1] !== 1'b0) begin bad++; $display("FAIL pad_head_ready: got %b want 0", rin[1]); end
      @(negedge clk);
      total++; if (rin[1] !== 1'b1) begin bad++; $display("FAIL pad_data_ready: got %b want 1", rin[1]); end
      drain(4);
      total++; if (cap1.size() != exp.size()) begin bad++; $display("FAIL pad_count: got %0d want %0d", cap1.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < cap1.size(); i++) begin
         total++; if (cap1[i] !== exp[i]) begin bad++; $display("FAIL pad_win%0d: got %h want %h", i, cap1[i], exp[i]); end
      end
   endtask

   task automatic test_multi_row();
      int  vals[$];
      wq_t exp;
      cap2.delete();
      rout[2] = 1'b1;
      for (int i = 1; i <= 7; i++) vals.push_back(i);
      for (int i = 11; i <= 17; i++) vals.push_back(i);
      exp = model(7, 2, 2, 0, vals);
      drive(2, vals, 0);
      drain(5);
      total++; if (cap2.size() != exp.size()) begin bad++; $display("FAIL rows_count: got %0d want %0d", cap2.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < cap2.size(); i++) begin
         total++; if (cap2[i] !== exp[i]) begin bad++; $display("FAIL rows_win%0d: got %h want %h", i, cap2[i], exp[i]); end
      end
   endtask

   task automatic test_backpressure();
      int  vals[$];
      wq_t exp;
      cap0.delete();
      rout[0] = 1'b1;
      for (int i = 1; i <= 8; i++) vals.push_back(i);
      exp = model(8, 2, 2, 0, vals);
      fork
         drive(0, vals, 0);
         begin
            int g;
            g = 0;
            while (vout[0] !== 1'b1 && g < 100) begin
               @(posedge clk);
               #1;
               g++;
            end
            rout[0] = 1'b0;
            total++; if (g >= 100) begin bad++; $display("FAIL bp_first_window_timeout: got none want valid"); end
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               total++; if (vout[0] !== 1'b1 || pk0 !== exp[0]) begin
                  bad++; $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=%h", c, vout[0], pk0, exp[0]);
               end
            end
            total++; if (rin[0] !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", rin[0]); end
            @(posedge clk);
            #1;
            rout[0] = 1'b1;
         end
      join
      drain(5);
      total++; if (cap0.size() != exp.size()) begin bad++; $display("FAIL bp_count: got %0d want %0d", cap0.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < cap0.size(); i++) begin
         total++; if (cap0[i] !== exp[i]) begin bad++; $display("FAIL bp_win%0d: got %h want %h", i, cap0[i], exp[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int  vals[$];
      wq_t exp;
      cap3.delete();
      cyc3.delete();
      rout[3] = 1'b1;
      for (int i = 1; i <= 8; i++) vals.push_back(i);
      exp = model(8, 3, 1, 0, vals);
      drive(3, vals, 0);
      drain(4);
      total++; if (cap3.size() != exp.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", cap3.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < cap3.size(); i++) begin
         total++; if (cap3[i] !== exp[i]) begin bad++; $display("FAIL b2b_win%0d: got %h want %h", i, cap3[i], exp[i]); end
      end
      for (int i = 1; i < cyc3.size(); i++) begin
         total++; if (cyc3[i] != cyc3[i-1] + 1) begin bad++; $display("FAIL b2b_gap%0d: got cycle %0d want %0d", i, cyc3[i], cyc3[i-1] + 1); end
      end
   endtask

   task automatic test_random();
      int  v1[$];
      int  v2[$];
      wq_t e1;
      wq_t e2;
      cap1.delete();
      cap2.delete();
      for (int i = 0; i < 15; i++) v1.push_back(int'($urandom_range(1, 255)));
      for (int i = 0; i < 14; i++) v2.push_back(int'($urandom_range(1, 255)));
      e1 = model(5, 3, 2, 1, v1);
      e2 = model(7, 2, 2, 0, v2);
      drive(1, v1, 1);
      rout[1] = 1'b1;
      drive(2, v2, 1);
      rout[2] = 1'b1;
      drain(20);
      total++; if (cap1.size() != e1.size()) begin bad++; $display("FAIL rnd1_count: got %0d want %0d", cap1.size(), e1.size()); end
      for (int i = 0; i < e1.size() && i < cap1.size(); i++) begin
         total++; if (cap1[i] !== e1[i]) begin bad++; $display("FAIL rnd1_win%0d: got %h want %h", i, cap1[i], e1[i]); end
      end
      total++; if (cap2.size() != e2.size()) begin bad++; $display("FAIL rnd2_count: got %0d want %0d", cap2.size(), e2.size()); end
      for (int i = 0; i < e2.size() && i < cap2.size(); i++) begin
         total++; if (cap2[i] !== e2[i]) begin bad++; $display("FAIL rnd2_win%0d: got %h want %h", i, cap2[i], e2[i]); end
      end
   endtask

   task automatic test_reset_midrow();
      int  part[$];
      int  vals[$];
      wq_t exp;
      rout[0] = 1'b0;
      for (int i = 1; i <= 3; i++) part.push_back(i);
      drive(0, part, 0);
      total++; if (vout[0] !== 1'b1) begin bad++; $display("FAIL midrow_pending: got %b want 1", vout[0]); end
      #2;
      rst = 1'b1;
      #1;
      total++; if (vout[0] !== 1'b0 || pk0 !== 32'h0) begin bad++; $display("FAIL midrow_reset: got v=%b d=%h want v=0 d=0", vout[0], pk0); end
      total++; if (rin[0] !== 1'b0) begin bad++; $display("FAIL midrow_reset_ready: got %b want 0", rin[0]); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rout[0] = 1'b1;
      cap0.delete();
      for (int i = 9; i <= 16; i++) vals.push_back(i);
      exp = model(8, 2, 2, 0, vals);
      drive(0, vals, 0);
      drain(5);
      total++; if (cap0.size() != exp.size()) begin bad++; $display("FAIL midrow_count: got %0d want %0d", cap0.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < cap0.size(); i++) begin
         total++; if (cap0[i] !== exp[i]) begin bad++; $display("FAIL midrow_win%0d: got %h want %h", i, cap0[i], exp[i]); end
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) din[i] = 8'h0;
      test_reset();
      test_basic();
      test_padding();
      test_multi_row();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_midrow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
